ad7324_spi_responder: RTL and testbench
=======================================

Name: ad7324_spi_responder

Overview:
- SPI slave that emulates the AD7324 4-channel ADC on the converter board's GPIO header.
- Drives 16-bit result frames (bit15=0, [14:13] channel ID, [12:0] two's-complement data) and accepts control-register writes on DIN.
- Lets the closed-loop controller's ADC read path be exercised in hardware-in-loop and simulation with programmable Vout/Temp/Vin/Iout values instead of a real ADC.

Parameters:
- DATA_W, 13, width of each channel sample and of the frame data field.
- FRAME_BITS, 16, SCLK falling edges per complete frame.
- SYNC_STAGES, 2, synchroniser depth on the SCLK, CS_n and DIN inputs.

Ports:
- CLK  in  1  system clock (CLOCK_50 on board); must be at least 8x the SCLK frequency.
- RSTn  in  1  asynchronous active-low reset.
- SCLK  in  1  SPI clock from master (asynchronous to CLK).
- CS_n  in  1  SPI chip select from master, active low.
- DIN  in  1  SPI data from master.
- DOUT  out  1  SPI data to master.
- DOUT_OE  out  1  output enable for the DOUT pad; tri-state when 0.
- ch0_data, ch1_data, ch2_data, ch3_data  in  DATA_W each  sample values (two's complement) for Vout, Temp, Vin and Iout.
- ctrl_reg  out  12  last accepted control-register contents.
- cur_chan  out  2  channel that will be returned in the next frame.
- frame_done  out  1  one-CLK pulse when a full frame completes.
- frame_err  out  1  one-CLK pulse when CS_n rises before FRAME_BITS edges.

Behaviour:
- Reset (RSTn low, asynchronous): DOUT=0, DOUT_OE=0, ctrl_reg=0, cur_chan=0, frame_done=0, frame_err=0, state=IDLE, bit counter=0, shift registers=0.
- Input handling: SCLK, CS_n and DIN each pass through a SYNC_STAGES flop synchroniser. Edges are then detected on the synchronised signals.
- Pin-to-internal latency is SYNC_STAGES+1 CLK cycles.
- State IDLE:
  - DOUT_OE=0.
  - On a CS_n falling edge: capture ch[cur_chan]_data into the transmit register as {1'b0, cur_chan, data}, drive DOUT=bit15, set DOUT_OE=1, clear the bit counter, go to SHIFT.
- State SHIFT:
  - On each SCLK falling edge: shift the current DIN into the receive register (MSB first) and increment the counter.
  - If the counter is below FRAME_BITS after the increment, DOUT advances to the next transmit bit in the same CLK.
  - When the counter reaches FRAME_BITS, go to DONE. DOUT holds 0 after the last bit.
  - If CS_n rises in SHIFT with counter < FRAME_BITS: pulse frame_err, set DOUT_OE=0, go to IDLE. ctrl_reg and cur_chan are unchanged and the received bits are discarded.
  - If a CS_n rising edge and an SCLK falling edge are detected in the same CLK, CS_n wins (abort).
- State DONE:
  - Wait for the CS_n rising edge. Any further SCLK edges are ignored.
  - On the CS_n rising edge: pulse frame_done, set DOUT_OE=0, apply the frame update (rules below), go to IDLE.
- Frame update, applied in the cycle of the CS_n rise after a full frame:
  - If rx[15]=1 (WRITE) and rx[14:13]=2'b00 (control register): ctrl_reg <= rx[11:0] and cur_chan <= rx[11:10]. The SEQ bit is ctrl_reg[3].
  - Otherwise, if the stored ctrl_reg[3]=1: cur_chan <= cur_chan+1, wrapping 3 to 0.
  - Otherwise: cur_chan is held.
  - Writes with rx[15]=1 and rx[14:13] not equal to 00 are accepted as frames but do not change ctrl_reg.
- Channel data is sampled only at CS_n fall. Changes to ch*_data during a frame do not affect the frame in progress.
- A CS_n falling edge while in DONE (CS_n glitch) is treated as a rise followed by a new start; the completed frame still commits.

Optional Feature:
- Macro RESP_ABORT_CNT_EN.
- When defined: adds output port abort_cnt (8 bits, reset 0). It increments on each frame_err pulse and saturates at 255; it does not wrap.
- When undefined: the port and the counter are absent, and all other behaviour is identical.

Test Plan:
- Plain read: after reset, ch0_data=13'h0123, 16-clock frame with DIN=0 -> DOUT sequence 16'h0123; frame_done pulses once; ctrl_reg=0; cur_chan=0.
- Channel select: frame with DIN=16'h8800 (WRITE, ADD=2) -> ctrl_reg=12'h800, cur_chan=2. Next frame with ch2_data=13'h1FFF returns 16'h5FFF.
- Sequencer: write DIN=16'h8008 (SEQ=1, ADD=0), then four frames with DIN=0 -> returned channel IDs 0,1,2,3, and a fifth frame returns 0.
- Abort: CS_n released after 7 SCLK edges -> frame_err pulses once, frame_done stays 0, cur_chan and ctrl_reg unchanged, DOUT_OE=0. With RESP_ABORT_CNT_EN defined, abort_cnt=1; after 300 aborts, abort_cnt=255.
- Ignored register: DIN=16'hA5FF (reg select 01) -> frame_done pulses; ctrl_reg unchanged.
- Reset mid-frame: assert RSTn low after 9 edges -> DOUT_OE=0 and state IDLE immediately. The next full frame returns channel 0 data correctly.

Source files
------------

// File: rtl/ad7324_spi_responder.sv
// AD7324 ADC emulator: SPI slave returning {0, chan, sample} frames and accepting control-register writes.
// Optional `RESP_ABORT_CNT_EN adds a saturating abort_cnt output counting aborted frames.
module ad7324_spi_responder #(
    parameter int DATA_W      = 13,
    parameter int FRAME_BITS  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              SCLK,
    input  logic              CS_n,
    input  logic              DIN,
    output logic              DOUT,
    output logic              DOUT_OE,
    input  logic [DATA_W-1:0] ch0_data,
    input  logic [DATA_W-1:0] ch1_data,
    input  logic [DATA_W-1:0] ch2_data,
    input  logic [DATA_W-1:0] ch3_data,
    output logic [11:0]       ctrl_reg,
    output logic [1:0]        cur_chan,
    output logic              frame_done,
    output logic              frame_err
`ifdef RESP_ABORT_CNT_EN
    ,
    output logic [7:0]        abort_cnt
`endif
);

    localparam int CNT_W = $clog2(FRAME_BITS + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q, cs_prev_d;
    logic [FRAME_BITS-1:0]  tx_q, tx_d;
    logic [FRAME_BITS-1:0]  rx_q, rx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   oe_q, oe_d;
    logic [11:0]            ctrl_q, ctrl_d;
    logic [1:0]             chan_q, chan_d;
    logic                   frame_done_q, frame_done_d;
    logic                   frame_err_q, frame_err_d;
`ifdef RESP_ABORT_CNT_EN
    logic [7:0]             abort_cnt_q, abort_cnt_d;
`endif

    logic                   sclk_s, cs_s, din_s;
    logic                   sclk_fall, cs_fall, cs_rise;
    logic [CNT_W-1:0]       cnt_inc;
    logic [11:0]            upd_ctrl;
    logic [1:0]             upd_chan;
    logic [1:0]             start_chan;
    logic [DATA_W-1:0]      sel_data;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign din_s     = din_sync_q[SYNC_STAGES-1];
    assign sclk_fall = sclk_prev_q & ~sclk_s;
    assign cs_fall   = cs_prev_q & ~cs_s;
    assign cs_rise   = ~cs_prev_q & cs_s;
    assign cnt_inc   = cnt_q + CNT_W'(1);

    always_comb begin
        sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
        cs_sync_d    = {cs_sync_q[SYNC_STAGES-2:0], CS_n};
        din_sync_d   = {din_sync_q[SYNC_STAGES-2:0], DIN};
        sclk_prev_d  = sclk_s;
        cs_prev_d    = cs_s;
        state_d      = state_q;
        tx_d         = tx_q;
        rx_d         = rx_q;
        cnt_d        = cnt_q;
        oe_d         = oe_q;
        ctrl_d       = ctrl_q;
        chan_d       = chan_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;

        // Commit values for a completed frame: register write, else optional sequencer step.
        upd_ctrl = ctrl_q;
        upd_chan = chan_q;
        if (rx_q[FRAME_BITS-1] && (rx_q[FRAME_BITS-2 -: 2] == 2'b00)) begin
            upd_ctrl = rx_q[11:0];
            upd_chan = rx_q[11:10];
        end else if (ctrl_q[3]) begin
            upd_chan = chan_q + 2'd1;
        end

        // A restart straight out of DONE must already see the committed channel.
        start_chan = (state_q == DONE) ? upd_chan : chan_q;
        sel_data   = ch0_data;
        case (start_chan)
            2'd0: sel_data = ch0_data;
            2'd1: sel_data = ch1_data;
            2'd2: sel_data = ch2_data;
            2'd3: sel_data = ch3_data;
            default: sel_data = ch0_data;
        endcase

        case (state_q)
            IDLE: begin
                oe_d = 1'b0;
                if (cs_fall) begin
                    tx_d    = FRAME_BITS'({1'b0, start_chan, sel_data});
                    rx_d    = '0;
                    cnt_d   = '0;
                    oe_d    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    frame_err_d = 1'b1;
                    oe_d        = 1'b0;
                    tx_d        = '0;
                    state_d     = IDLE;
                end else if (sclk_fall) begin
                    rx_d  = {rx_q[FRAME_BITS-2:0], din_s};
                    tx_d  = {tx_q[FRAME_BITS-2:0], 1'b0};
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(FRAME_BITS)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (cs_rise || cs_fall) begin
                    frame_done_d = 1'b1;
                    ctrl_d       = upd_ctrl;
                    chan_d       = upd_chan;
                    oe_d         = 1'b0;
                    tx_d         = '0;
                    state_d      = IDLE;
                    if (cs_fall) begin
                        tx_d    = FRAME_BITS'({1'b0, start_chan, sel_data});
                        rx_d    = '0;
                        cnt_d   = '0;
                        oe_d    = 1'b1;
                        state_d = SHIFT;
                    end
                end
            end
            default: begin
                oe_d    = 1'b0;
                tx_d    = '0;
                state_d = IDLE;
            end
        endcase
`ifdef RESP_ABORT_CNT_EN
        abort_cnt_d = abort_cnt_q;
        if (frame_err_d && (abort_cnt_q != 8'hFF)) begin
            abort_cnt_d = abort_cnt_q + 8'd1;
        end
`endif
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sclk_sync_q  <= '1;
            cs_sync_q    <= '1;
            din_sync_q   <= '0;
            sclk_prev_q  <= 1'b1;
            cs_prev_q    <= 1'b1;
            state_q      <= IDLE;
            tx_q         <= '0;
            rx_q         <= '0;
            cnt_q        <= '0;
            oe_q         <= 1'b0;
            ctrl_q       <= '0;
            chan_q       <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef RESP_ABORT_CNT_EN
            abort_cnt_q  <= '0;
`endif
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            cs_sync_q    <= cs_sync_d;
            din_sync_q   <= din_sync_d;
            sclk_prev_q  <= sclk_prev_d;
            cs_prev_q    <= cs_prev_d;
            state_q      <= state_d;
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            cnt_q        <= cnt_d;
            oe_q         <= oe_d;
            ctrl_q       <= ctrl_d;
            chan_q       <= chan_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
`ifdef RESP_ABORT_CNT_EN
            abort_cnt_q  <= abort_cnt_d;
`endif
        end
    end

    assign DOUT       = tx_q[FRAME_BITS-1];
    assign DOUT_OE    = oe_q;
    assign ctrl_reg   = ctrl_q;
    assign cur_chan   = chan_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
`ifdef RESP_ABORT_CNT_EN
    assign abort_cnt  = abort_cnt_q;
`endif

endmodule

// File: tb/tb_ad7324_spi_responder.sv
// Directed bench for ad7324_spi_responder: plain reads, register writes, sequencer, aborts, mid-frame reset.
module tb_ad7324_spi_responder;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        SCLK;
    logic        CS_n;
    logic        DIN;
    logic        DOUT;
    logic        DOUT_OE;
    logic [12:0] ch0_data, ch1_data, ch2_data, ch3_data;
    logic [11:0] ctrl_reg;
    logic [1:0]  cur_chan;
    logic        frame_done;
    logic        frame_err;
`ifdef RESP_ABORT_CNT_EN
    logic [7:0]  abort_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int done_total = 0;
    int err_total  = 0;
    logic        oe_mid;
    logic [15:0] rd;

    ad7324_spi_responder dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .SCLK      (SCLK),
        .CS_n      (CS_n),
        .DIN       (DIN),
        .DOUT      (DOUT),
        .DOUT_OE   (DOUT_OE),
        .ch0_data  (ch0_data),
        .ch1_data  (ch1_data),
        .ch2_data  (ch2_data),
        .ch3_data  (ch3_data),
        .ctrl_reg  (ctrl_reg),
        .cur_chan  (cur_chan),
        .frame_done(frame_done),
        .frame_err (frame_err)
`ifdef RESP_ABORT_CNT_EN
        ,
        .abort_cnt (abort_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (frame_done) done_total++;
        if (frame_err)  err_total++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // SCLK idles high; DOUT is sampled just before each falling edge, DIN held across it.
    task automatic do_frame(input logic [15:0] din_w, input int nedges, input bit hold_cs,
                            output logic [15:0] dout_w);
        dout_w = '0;
        oe_mid = 1'b0;
        CS_n = 1'b0;
        clks(8);
        for (int i = 0; i < nedges; i++) begin
            DIN = din_w[15-i];
            clks(8);
            dout_w[15-i] = DOUT;
            if (i == 0) oe_mid = DOUT_OE;
            SCLK = 1'b0;
            clks(8);
            SCLK = 1'b1;
        end
        clks(8);
        if (!hold_cs) begin
            CS_n = 1'b1;
            clks(8);
        end
        $display("frame din=%04h edges=%0d dout=%04h ctrl=%03h chan=%0d", din_w, nedges, dout_w,
                 ctrl_reg, cur_chan);
    endtask

    task automatic read_frame(input string tag, input logic [15:0] din_w, input logic [15:0] exp_dout,
                              input logic [11:0] exp_ctrl, input logic [1:0] exp_chan);
        int d0;
        int e0;
        d0 = done_total;
        e0 = err_total;
        do_frame(din_w, 16, 1'b0, rd);
        check({tag, "_dout"}, 32'(rd), 32'(exp_dout));
        check({tag, "_oe_mid"}, 32'(oe_mid), 32'd1);
        check({tag, "_done"}, 32'(done_total - d0), 32'd1);
        check({tag, "_err"}, 32'(err_total - e0), 32'd0);
        check({tag, "_ctrl"}, 32'(ctrl_reg), 32'(exp_ctrl));
        check({tag, "_chan"}, 32'(cur_chan), 32'(exp_chan));
        check({tag, "_oe_end"}, 32'(DOUT_OE), 32'd0);
    endtask

    initial begin
        int d0;
        int e0;
        RSTn = 1'b0;
        CS_n = 1'b1;
        SCLK = 1'b1;
        DIN  = 1'b0;
        ch0_data = 13'h0123;
        ch1_data = 13'h0ABC;
        ch2_data = 13'h1FFF;
        ch3_data = 13'h1000;
        clks(3);
        check("rst_dout", 32'(DOUT), 32'd0);
        check("rst_oe", 32'(DOUT_OE), 32'd0);
        check("rst_ctrl", 32'(ctrl_reg), 32'd0);
        check("rst_chan", 32'(cur_chan), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
`ifdef RESP_ABORT_CNT_EN
        check("rst_abort_cnt", 32'(abort_cnt), 32'd0);
`endif
        RSTn = 1'b1;
        clks(4);

        read_frame("plain", 16'h0000, 16'h0123, 12'h000, 2'd0);
        read_frame("wr_add2", 16'h8800, 16'h0123, 12'h800, 2'd2);
        read_frame("rd_ch2", 16'h0000, 16'h5FFF, 12'h800, 2'd2);
        read_frame("wr_seq", 16'h8008, 16'h5FFF, 12'h008, 2'd0);
        read_frame("seq0", 16'h0000, 16'h0123, 12'h008, 2'd1);
        read_frame("seq1", 16'h0000, 16'h2ABC, 12'h008, 2'd2);
        read_frame("seq2", 16'h0000, 16'h5FFF, 12'h008, 2'd3);
        read_frame("seq3", 16'h0000, 16'h7000, 12'h008, 2'd0);
        read_frame("seq4", 16'h0000, 16'h0123, 12'h008, 2'd1);

        // Abort after 7 falling edges: no commit, channel and control untouched.
        d0 = done_total;
        e0 = err_total;
        do_frame(16'h8800, 7, 1'b0, rd);
        check("abort_err", 32'(err_total - e0), 32'd1);
        check("abort_done", 32'(done_total - d0), 32'd0);
        check("abort_chan", 32'(cur_chan), 32'd1);
        check("abort_ctrl", 32'(ctrl_reg), 32'h008);
        check("abort_oe", 32'(DOUT_OE), 32'd0);
`ifdef RESP_ABORT_CNT_EN
        check("abort_cnt_1", 32'(abort_cnt), 32'd1);
`endif

        // Write to register select 01: frame completes, ctrl unchanged, sequencer still steps.
        read_frame("ign_reg", 16'hA5FF, 16'h2ABC, 12'h008, 2'd2);

        // Reset asserted in the middle of a frame.
        do_frame(16'h0000, 9, 1'b1, rd);
        check("mid_oe_before", 32'(DOUT_OE), 32'd1);
        RSTn = 1'b0;
        #1;
        check("mid_rst_oe", 32'(DOUT_OE), 32'd0);
        check("mid_rst_dout", 32'(DOUT), 32'd0);
        clks(2);
        CS_n = 1'b1;
        clks(4);
        RSTn = 1'b1;
        clks(8);
        check("mid_rst_chan", 32'(cur_chan), 32'd0);
        check("mid_rst_ctrl", 32'(ctrl_reg), 32'd0);
        read_frame("post_rst", 16'h0000, 16'h0123, 12'h000, 2'd0);

`ifdef RESP_ABORT_CNT_EN
        check("abort_cnt_rst", 32'(abort_cnt), 32'd0);
        for (int k = 0; k < 300; k++) begin
            CS_n = 1'b0;
            clks(8);
            CS_n = 1'b1;
            clks(8);
        end
        check("abort_cnt_sat", 32'(abort_cnt), 32'd255);
        $display("abort burst of 300 done abort_cnt=%0d", abort_cnt);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
